// File: rtl/sgnmpy_seq_pkg.sv
// rtl/sgnmpy_seq_pkg.sv - shared types and helpers for the sequential sign/magnitude multiplier
//
// Purpose: decoded sign-mode view of the request and the iteration-count helper
//          used by both sgnmpy_seq and umpy_seq_core.
// Ports:   none (package).
package sgnmpy_seq_pkg;

  // Decoded view of the 2-bit sign-mode input: bit 1 -> A signed, bit 0 -> B signed.
  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } sgn_mode_t;

  // Number of shift-add iterations for one product. A non-positive digit width
  // is rejected at elaboration; returning 1 keeps the arithmetic defined until then.
  function automatic int num_steps(input int nb, input int bpc);
    return (bpc < 1) ? 1 : nb / bpc;
  endfunction

endpackage

// File: rtl/umpy_seq_core.sv
// rtl/umpy_seq_core.sv - unsigned radix-2^BPC shift-add multiplier iteration
//
// Purpose: multiplies two unsigned magnitudes, BPC bits of B per step.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset, clears all state
//   i_load   load i_a/i_b, clear accumulator, load step counter
//   i_step   perform one shift-add iteration (ignored once the counter is 0)
//   i_a      multiplicand magnitude (NA bits)
//   i_b      multiplier magnitude (NB bits)
//   o_acc    running / final product (NA+NB bits)
//   o_last   high while the next step is the final one
module umpy_seq_core
  import sgnmpy_seq_pkg::*;
#(
  parameter int NA  = 32,
  parameter int NB  = 32,
  parameter int BPC = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [NA-1:0]    i_a,
  input  logic [NB-1:0]    i_b,
  output logic [NA+NB-1:0] o_acc,
  output logic             o_last
);

  localparam int STEPS = num_steps(NB, BPC);
  localparam int CW    = $clog2(STEPS + 1);
  localparam int PW    = NA + NB;

  logic [PW-1:0] a_sh;     // |A| pre-shifted to the weight of the current digit
  logic [PW-1:0] acc;
  logic [PW-1:0] partial;
  logic [NB-1:0] b_sh;     // remaining digits of |B|, low digit first
  logic [CW-1:0] cnt;

  // Each partial product is bounded by the final product, so it always fits in PW bits.
  assign partial = a_sh * PW'(b_sh[BPC-1:0]);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_sh <= '0;
      acc  <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (i_load) begin
      a_sh <= PW'(i_a);
      acc  <= '0;
      b_sh <= i_b;
      cnt  <= CW'(STEPS);
    end else if (i_step && (cnt != '0)) begin
      acc  <= acc + partial;
      a_sh <= a_sh << BPC;
      b_sh <= b_sh >> BPC;
      cnt  <= cnt - CW'(1);
    end
  end

  assign o_acc  = acc;
  assign o_last = (cnt == CW'(1));

endmodule

// File: rtl/sgnmpy_seq.sv
// rtl/sgnmpy_seq.sv - sequential multiplier with per-operand signed/unsigned mode
//
// Purpose: accepts one request at a time, converts operands to magnitudes,
//          runs the unsigned shift-add core, then applies the result sign.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset
//   i_stb    request strobe, accepted when i_stb && !o_busy
//   i_sgn    [1] A signed, [0] B signed
//   i_a      operand A (NA bits)
//   i_b      operand B (NB bits)
//   i_aux    tag returned with the result
//   o_busy   high while a request is in progress
//   o_valid  one-cycle result pulse
//   o_p      product (NA+NB bits), held until the next result
//   o_aux    tag of the request that produced o_p
module sgnmpy_seq
  import sgnmpy_seq_pkg::*;
#(
  parameter int NA   = 32,
  parameter int NB   = 32,
  parameter int BPC  = 4,
  parameter int NAUX = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stb,
  input  logic [1:0]       i_sgn,
  input  logic [NA-1:0]    i_a,
  input  logic [NB-1:0]    i_b,
  input  logic [NAUX-1:0]  i_aux,
  output logic             o_busy,
  output logic             o_valid,
  output logic [NA+NB-1:0] o_p,
  output logic [NAUX-1:0]  o_aux
);

  generate
    if (BPC < 1) begin : g_bad_bpc
      $error("sgnmpy_seq: BPC must be at least 1");
    end else if (NB % BPC != 0) begin : g_bad_nb
      $error("sgnmpy_seq: NB must be a multiple of BPC");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state;
  sgn_mode_t         mode;
  logic              a_neg;
  logic              b_neg;
  logic              start;
  logic [NA-1:0]     a_mag;
  logic [NB-1:0]     b_mag;
  logic              sign_q;
  logic [NAUX-1:0]   aux_q;
  logic [NA+NB-1:0]  acc;
  logic              core_last;

  assign mode  = sgn_mode_t'(i_sgn);
  assign a_neg = mode.a_signed & i_a[NA-1];
  assign b_neg = mode.b_signed & i_b[NB-1];

  // Negation stays in the operand's own width: the most negative value maps to
  // 2^(N-1), which is still representable as an unsigned magnitude.
  assign a_mag = a_neg ? (~i_a + NA'(1)) : i_a;
  assign b_mag = b_neg ? (~i_b + NB'(1)) : i_b;

  assign start = (state == S_IDLE) && i_stb && !o_busy;

  umpy_seq_core #(
    .NA  (NA),
    .NB  (NB),
    .BPC (BPC)
  ) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (start),
    .i_step  (state == S_RUN),
    .i_a     (a_mag),
    .i_b     (b_mag),
    .o_acc   (acc),
    .o_last  (core_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_p     <= '0;
      o_aux   <= '0;
      sign_q  <= 1'b0;
      aux_q   <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_q <= a_neg ^ b_neg;
            aux_q  <= i_aux;
            o_busy <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          // core_last means this edge performs the final step
          if (core_last) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          o_p     <= sign_q ? -acc : acc;
          o_aux   <= aux_q;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sgnmpy_seq.sv
// tb/tb_sgnmpy_seq.sv - scoreboard bench for sgnmpy_seq in two configurations
module tb_sgnmpy_seq;

  typedef struct packed {
    logic [63:0] p;
    logic [3:0]  aux;
    logic [31:0] due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // instance 0: NA=NB=32, BPC=4
  logic        rst0 = 1'b1;
  logic        stb0 = 1'b0;
  logic [1:0]  sgn0 = '0;
  logic [31:0] a0 = '0, b0 = '0;
  logic [3:0]  aux0 = '0;
  logic        busy0, val0;
  logic [63:0] p0;
  logic [3:0]  oaux0;

  // instance 1: NA=12, NB=8, BPC=1
  logic        rst1 = 1'b1;
  logic        stb1 = 1'b0;
  logic [1:0]  sgn1 = '0;
  logic [11:0] a1 = '0;
  logic [7:0]  b1 = '0;
  logic [3:0]  aux1 = '0;
  logic        busy1, val1;
  logic [19:0] p1;
  logic [3:0]  oaux1;

  sgnmpy_seq #(.NA(32), .NB(32), .BPC(4), .NAUX(4)) dut0 (
    .i_clk(clk), .i_reset(rst0), .i_stb(stb0), .i_sgn(sgn0), .i_a(a0), .i_b(b0),
    .i_aux(aux0), .o_busy(busy0), .o_valid(val0), .o_p(p0), .o_aux(oaux0)
  );

  sgnmpy_seq #(.NA(12), .NB(8), .BPC(1), .NAUX(4)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_stb(stb1), .i_sgn(sgn1), .i_a(a1), .i_b(b1),
    .i_aux(aux1), .o_busy(busy1), .o_valid(val1), .o_p(p1), .o_aux(oaux1)
  );

  // per-instance reference state
  exp_t        q [2][$];
  int          kacc [2] = '{0, 0};   // acceptance edge of the latest request
  int          free [2] = '{0, 0};   // first edge at which a new request is taken
  bit          act  [2] = '{0, 0};
  logic [63:0] lp   [2] = '{64'd0, 64'd0};
  logic [3:0]  la   [2] = '{4'd0, 4'd0};

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act_v, exp_v);
    end
  endtask

  // exact product from the mathematical operand values
  function automatic logic [63:0] ref_prod(input logic [1:0] s, input logic [63:0] a,
                                           input logic [63:0] b, input int na, input int nb);
    logic signed [129:0] ea, eb, pr;
    ea = {66'b0, a};
    eb = {66'b0, b};
    if (s[1] && a[na-1]) ea = ea - (130'sd1 <<< na);
    if (s[0] && b[nb-1]) eb = eb - (130'sd1 <<< nb);
    pr = ea * eb;
    return pr[63:0];
  endfunction

  function automatic logic [63:0] pick(input int n);
    logic [63:0] m, v;
    m = (64'd1 << n) - 64'd1;
    case ($urandom_range(0, 5))
      0:       v = 64'd1 << (n - 1);
      1:       v = m;
      2:       v = 64'd0;
      3:       v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  // Request presented before edge cyc+1; taken only if the model says the unit is free.
  task automatic model_issue(input int d, input logic stb, input logic [1:0] sgn,
                             input logic [63:0] a, input logic [63:0] b, input logic [3:0] aux,
                             input logic fixed, input logic [63:0] fp);
    int   k, na, nb, steps;
    exp_t e;
    na    = (d == 0) ? 32 : 12;
    nb    = (d == 0) ? 32 : 8;
    steps = (d == 0) ? 32 / 4 : 8 / 1;
    k     = cyc + 1;
    if (stb && k >= free[d]) begin
      e.p   = fixed ? fp : (ref_prod(sgn, a, b, na, nb) & ((64'd1 << (na + nb)) - 64'd1));
      e.aux = aux;
      e.due = 32'(k + steps + 1);
      q[d].push_back(e);
      kacc[d] = k;
      free[d] = k + steps + 2;
      act[d]  = 1'b1;
    end
  endtask

  task automatic monitor_step(input int d, input logic busy, input logic valid,
                              input logic [63:0] p, input logic [3:0] aux);
    logic bexp;
    exp_t e;
    int   steps;
    steps = 8;
    bexp  = act[d] && (cyc >= kacc[d]) && (cyc < kacc[d] + steps + 1);
    chk($sformatf("busy%0d", d), {63'b0, busy}, {63'b0, bexp});
    while (q[d].size() > 0 && int'(q[d][0].due) < cyc) begin
      n_vec++;
      n_bad++;
      $display("FAIL missing_valid%0d: no result by cycle %0d, expected at %0d", d, cyc, q[d][0].due);
      e = q[d].pop_front();
    end
    if (valid) begin
      if (q[d].size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid%0d: o_valid at cycle %0d with nothing outstanding (o_p=%h)", d, cyc, p);
      end else begin
        e = q[d].pop_front();
        chk($sformatf("product%0d", d), p, e.p);
        chk($sformatf("aux%0d", d), {60'b0, aux}, {60'b0, e.aux});
        chk($sformatf("latency%0d", d), 64'(cyc), 64'(e.due));
        lp[d] = e.p;
        la[d] = e.aux;
      end
    end else begin
      chk($sformatf("hold_p%0d", d), p, lp[d]);
      chk($sformatf("hold_aux%0d", d), {60'b0, aux}, {60'b0, la[d]});
    end
  endtask

  always @(negedge clk) if (!rst0) monitor_step(0, busy0, val0, p0, oaux0);
  always @(negedge clk) if (!rst1) monitor_step(1, busy1, val1, {44'b0, p1}, oaux1);

  task automatic set0(input logic stb, input logic [1:0] sgn, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] aux, input logic fixed,
                      input logic [63:0] fp);
    stb0 = stb; sgn0 = sgn; a0 = a; b0 = b; aux0 = aux;
    model_issue(0, stb, sgn, {32'b0, a}, {32'b0, b}, aux, fixed, fp);
  endtask

  task automatic drv0(input logic stb, input logic [1:0] sgn, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] aux, input logic fixed,
                      input logic [63:0] fp);
    @(negedge clk);
    #2;
    set0(stb, sgn, a, b, aux, fixed, fp);
  endtask

  task automatic idle0(input int n);
    repeat (n) drv0(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0, 64'd0);
  endtask

  task automatic set1(input logic stb, input logic [1:0] sgn, input logic [11:0] a,
                      input logic [7:0] b, input logic [3:0] aux);
    stb1 = stb; sgn1 = sgn; a1 = a; b1 = b; aux1 = aux;
    model_issue(1, stb, sgn, {52'b0, a}, {56'b0, b}, aux, 1'b0, 64'd0);
  endtask

  task automatic stim0();
    // first request on the first edge after reset release
    @(negedge clk);
    #2;
    rst0 = 1'b0;
    set0(1'b1, 2'b11, 32'hFFFF_FFFD, 32'd7, 4'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    idle0(11);
    drv0(1'b1, 2'b11, 32'h8000_0000, 32'h8000_0000, 4'd2, 1'b1, 64'h4000_0000_0000_0000);
    idle0(11);
    drv0(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 4'd3, 1'b1, 64'h4000_0000_0000_0000);
    idle0(11);
    drv0(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b1, 64'hFFFF_FFFF_0000_0001);
    idle0(11);
    // strobe held high with a new operand set every cycle
    repeat (60) drv0(1'b1, 2'($urandom), 32'(pick(32)), 32'(pick(32)), 4'($urandom), 1'b0, 64'd0);
    idle0(12);
    // abort mid-run
    drv0(1'b1, 2'b11, 32'(pick(32)), 32'(pick(32)), 4'd9, 1'b0, 64'd0);
    idle0(4);
    @(negedge clk);
    #2;
    rst0 = 1'b1;
    #1;
    chk("abort_busy", {63'b0, busy0}, 64'd0);
    chk("abort_valid", {63'b0, val0}, 64'd0);
    chk("abort_p", p0, 64'd0);
    chk("abort_aux", {60'b0, oaux0}, 64'd0);
    q[0].delete();
    act[0]  = 1'b0;
    free[0] = 0;
    lp[0]   = 64'd0;
    la[0]   = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst0 = 1'b0;
    set0(1'b1, 2'b01, 32'd1000, 32'hFFFF_FFFE, 4'd6, 1'b1, 64'hFFFF_FFFF_FFFF_F830);
    idle0(11);
    repeat (300) drv0(1'($urandom_range(0, 1)), 2'($urandom), 32'(pick(32)), 32'(pick(32)),
                      4'($urandom), 1'b0, 64'd0);
    idle0(12);
  endtask

  task automatic stim1();
    @(negedge clk);
    #2;
    rst1 = 1'b0;
    repeat (30000) begin
      @(negedge clk);
      #2;
      set1($urandom_range(0, 9) != 0, 2'($urandom), 12'(pick(12)), 8'(pick(8)), 4'($urandom));
    end
    @(negedge clk);
    #2;
    set1(1'b0, 2'b00, 12'd0, 8'd0, 4'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy0", {63'b0, busy0}, 64'd0);
    chk("rst_valid0", {63'b0, val0}, 64'd0);
    chk("rst_p0", p0, 64'd0);
    chk("rst_aux0", {60'b0, oaux0}, 64'd0);
    chk("rst_busy1", {63'b0, busy1}, 64'd0);
    chk("rst_valid1", {63'b0, val1}, 64'd0);
    chk("rst_p1", {44'b0, p1}, 64'd0);
    chk("rst_aux1", {60'b0, oaux1}, 64'd0);
    fork
      stim0();
      stim1();
    join
    repeat (15) @(negedge clk);
    chk("drained0", 64'(q[0].size()), 64'd0);
    chk("drained1", 64'(q[1].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
